// File: rtl/ex_pkg.sv
// ---------------------------------------------------------------------------
// ex_pkg -- definitions shared by the EX stage.
//
// Contents:
//   div_state_t             divide sequencer states
//   DIV_HI_LSB / DIV_LO_MSB HI/LO field boundaries of the packed divide
//                           result {remainder, quotient} at the default
//                           32-bit datapath
//   EXE_*_OP                ALU operation codes, including DIV/DIVU
//   is_div_op()             true for the opcodes steered to the divider
// ---------------------------------------------------------------------------
package ex_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIVZERO = 2'd1,
        BUSY    = 2'd2,
        DONE    = 2'd3
    } div_state_t;

    // Packed result is {HI = remainder, LO = quotient}
    localparam int DIV_DATA_W = 32;
    localparam int DIV_HI_LSB = DIV_DATA_W;
    localparam int DIV_LO_MSB = DIV_DATA_W - 1;

    // ALU operation codes
    localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
    localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    function automatic logic is_div_op(input logic [7:0] aluop);
        return (aluop == EXE_DIV_OP) || (aluop == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/ex_div_step.sv
// ---------------------------------------------------------------------------
// ex_div_step -- one combinational step of a radix-2 restoring divide.
//
// Ports:
//   rem       [DATA_W-1:0]  partial remainder before this step
//   dvd_msb                 dividend bit shifted into the remainder
//   divisor   [DATA_W-1:0]  unsigned divisor (non-zero)
//   rem_next  [DATA_W-1:0]  partial remainder after this step
//   q_bit                   quotient bit produced by this step
// ---------------------------------------------------------------------------
module ex_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem,
    input  logic              dvd_msb,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next,
    output logic              q_bit
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] trial;

    // rem < divisor on entry, so the shifted value always fits DATA_W+1 bits
    // and the top bit of the trial difference is a clean sign bit.
    assign shifted  = {rem, dvd_msb};
    assign trial    = shifted - {1'b0, divisor};
    assign q_bit    = ~trial[DATA_W];
    assign rem_next = q_bit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];

endmodule

// File: rtl/ex_div_ctrl.sv
// ---------------------------------------------------------------------------
// ex_div_ctrl -- multi-cycle DIV/DIVU sequencer beside the EX-stage ALU.
//
// Radix-2 restoring divide, one quotient bit per cycle. The pipeline is
// stalled while the divide runs; the result is returned as
// {remainder, quotient} (HI/LO). A flush annuls an in-flight divide.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   div_start_i     request; held high until div_ready_o is seen
//   div_signed_i    1 = DIV (two's complement), 0 = DIVU
//   div_opdata1_i   dividend
//   div_opdata2_i   divisor
//   div_annul_i     flush; aborts a BUSY/DIVZERO operation
//   div_result_o    {remainder, quotient}, registered
//   div_ready_o     result valid, registered
//   div_stall_o     stall request, combinational
//
// Build option:
//   EX_DIV_EARLY_OUT_EN  when defined, a divisor whose magnitude exceeds the
//                        dividend's skips the iterations (quotient 0,
//                        remainder = raw dividend).
// ---------------------------------------------------------------------------
module ex_div_ctrl
    import ex_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                div_start_i,
    input  logic                div_signed_i,
    input  logic [DATA_W-1:0]   div_opdata1_i,
    input  logic [DATA_W-1:0]   div_opdata2_i,
    input  logic                div_annul_i,
    output logic [2*DATA_W-1:0] div_result_o,
    output logic                div_ready_o,
    output logic                div_stall_o
);

    div_state_t          state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [DATA_W-1:0]   rem_reg, rem_next;
    logic [DATA_W-1:0]   dvd_reg, dvd_next;     // dividend in, quotient out
    logic [DATA_W-1:0]   dsr_reg, dsr_next;
    logic                sign_q_reg, sign_q_next;
    logic                sign_r_reg, sign_r_next;
    logic                fix_reg, fix_next;     // apply sign correction in DONE
    logic                ready_reg, ready_next;
    logic [2*DATA_W-1:0] result_reg, result_next;

    logic [DATA_W-1:0]   abs_op1, abs_op2;
    logic [DATA_W-1:0]   step_rem;
    logic                step_q;
    logic [DATA_W-1:0]   quo_fix, rem_fix;

    // Magnitudes as unsigned values; the most negative number maps onto itself.
    assign abs_op1 = (div_signed_i && div_opdata1_i[DATA_W-1]) ? -div_opdata1_i : div_opdata1_i;
    assign abs_op2 = (div_signed_i && div_opdata2_i[DATA_W-1]) ? -div_opdata2_i : div_opdata2_i;

    assign quo_fix = (fix_reg && sign_q_reg) ? -dvd_reg : dvd_reg;
    assign rem_fix = (fix_reg && sign_r_reg) ? -rem_reg : rem_reg;

    ex_div_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .rem      (rem_reg),
        .dvd_msb  (dvd_reg[DATA_W-1]),
        .divisor  (dsr_reg),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        rem_next    = rem_reg;
        dvd_next    = dvd_reg;
        dsr_next    = dsr_reg;
        sign_q_next = sign_q_reg;
        sign_r_next = sign_r_reg;
        fix_next    = fix_reg;
        ready_next  = ready_reg;
        result_next = result_reg;

        case (state_reg)
            IDLE: begin
                if (div_start_i && !div_annul_i) begin
                    if (div_opdata2_i == '0) begin
                        // Divide by zero: quotient all ones, remainder raw
                        // dividend, never sign corrected.
                        state_next = DIVZERO;
                        rem_next   = div_opdata1_i;
                        dvd_next   = '1;
                        fix_next   = 1'b0;
                    end
`ifdef EX_DIV_EARLY_OUT_EN
                    else if (abs_op2 > abs_op1) begin
                        state_next = DONE;
                        rem_next   = div_opdata1_i;
                        dvd_next   = '0;
                        fix_next   = 1'b0;
                    end
`endif
                    else begin
                        state_next  = BUSY;
                        cnt_next    = '0;
                        rem_next    = '0;
                        dvd_next    = abs_op1;
                        dsr_next    = abs_op2;
                        sign_q_next = div_opdata1_i[DATA_W-1] ^ div_opdata2_i[DATA_W-1];
                        sign_r_next = div_opdata1_i[DATA_W-1];
                        fix_next    = div_signed_i;
                    end
                end
            end

            BUSY: begin
                if (div_annul_i) begin
                    state_next = IDLE;
                end else begin
                    rem_next = step_rem;
                    dvd_next = {dvd_reg[DATA_W-2:0], step_q};
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(DATA_W - 1)) begin
                        state_next = DONE;
                    end
                end
            end

            DIVZERO: begin
                state_next = div_annul_i ? IDLE : DONE;
            end

            DONE: begin
                // First DONE cycle commits the result; afterwards it holds
                // until the request is withdrawn. Annul is not looked at.
                if (!ready_reg) begin
                    ready_next  = 1'b1;
                    result_next = {rem_fix, quo_fix};
                end else if (!div_start_i) begin
                    state_next  = IDLE;
                    ready_next  = 1'b0;
                    result_next = '0;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            rem_reg    <= '0;
            dvd_reg    <= '0;
            dsr_reg    <= '0;
            sign_q_reg <= 1'b0;
            sign_r_reg <= 1'b0;
            fix_reg    <= 1'b0;
            ready_reg  <= 1'b0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            rem_reg    <= rem_next;
            dvd_reg    <= dvd_next;
            dsr_reg    <= dsr_next;
            sign_q_reg <= sign_q_next;
            sign_r_reg <= sign_r_next;
            fix_reg    <= fix_next;
            ready_reg  <= ready_next;
            result_reg <= result_next;
        end
    end

    always_comb begin
        div_stall_o = 1'b0;
        case (state_reg)
            IDLE:          div_stall_o = div_start_i && !div_annul_i;
            BUSY, DIVZERO: div_stall_o = !div_annul_i;
            default:       div_stall_o = 1'b0;
        endcase
    end

    assign div_result_o = result_reg;
    assign div_ready_o  = ready_reg;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ex_div_ctrl -- self-checking bench for ex_div_ctrl (default build).
// Table of directed divides plus hand-written annul / hold / reset sequences.
// ---------------------------------------------------------------------------
module tb_ex_div_ctrl;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, sgn, annul;
    logic [31:0] op1, op2;
    logic [63:0] result;
    logic        ready, stall;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ex_div_ctrl #(.DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .div_start_i   (start),
        .div_signed_i  (sgn),
        .div_opdata1_i (op1),
        .div_opdata2_i (op2),
        .div_annul_i   (annul),
        .div_result_o  (result),
        .div_ready_o   (ready),
        .div_stall_o   (stall)
    );

    typedef struct {
        string       name;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          hold;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge with the DUT in IDLE.
    task automatic run_div(input string name, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] hi,
                           input logic [31:0] lo, input int lat, input int hold);
        int edges;
        int stalls;
        sgn = s; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
        #1;
        stalls = stall ? 1 : 0;
        edges  = 0;
        while (!ready && edges < 100) begin
            tick();
            edges++;
            if (stall) stalls++;
        end
        check({name, ".ready"}, 64'(ready), 64'd1);
        check({name, ".latency"}, 64'(edges - 1), 64'(lat));
        check({name, ".stall_cycles"}, 64'(stalls), 64'(lat));
        check({name, ".result"}, result, {hi, lo});
        $display("div %s s=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h lat=%0d",
                 name, s, a, b, result[63:DIV_HI_LSB], result[DIV_LO_MSB:0], edges - 1);
        // New operands and an annul while holding must not disturb DONE.
        op1 = ~a; op2 = 32'd3; sgn = ~s;
        for (int i = 0; i < hold; i++) begin
            annul = (i == 1);
            tick();
            check({name, ".hold_ready"}, 64'(ready), 64'd1);
            check({name, ".hold_result"}, result, {hi, lo});
            check({name, ".hold_stall"}, 64'(stall), 64'd0);
        end
        annul = 1'b0;
        start = 1'b0;
        tick();
        check({name, ".drop_ready"}, 64'(ready), 64'd0);
        check({name, ".drop_result"}, result, 64'd0);
    endtask

    initial begin
        vecs[0] = '{"u100_7",    1'b0, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 33, 5};
        vecs[1] = '{"s-7_2",     1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 0};
        vecs[2] = '{"u_divzero", 1'b0, 32'h1234_5678, 32'h0,         32'h1234_5678, 32'hFFFF_FFFF,  2, 2};
        vecs[3] = '{"s_ovf",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 33, 0};
        vecs[4] = '{"u_max_1",   1'b0, 32'hFFFF_FFFF, 32'h1,         32'h0,         32'hFFFF_FFFF, 33, 0};
        vecs[5] = '{"s7_-2",     1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33, 0};
        vecs[6] = '{"s-7_-2",    1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 33, 0};
        vecs[7] = '{"s_divzero", 1'b1, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF,  2, 0};
        vecs[8] = '{"u_big_2",   1'b0, 32'hFFFF_FFF9, 32'h2,         32'h0000_0001, 32'h7FFF_FFFC, 33, 0};
        vecs[9] = '{"u5_10",     1'b0, 32'd5,         32'd10,        32'd5,         32'd0,         33, 0};

        rst = 1'b1; start = 1'b0; sgn = 1'b0; annul = 1'b0; op1 = '0; op2 = '0;
        repeat (3) tick();
        check("reset.ready", 64'(ready), 64'd0);
        check("reset.result", result, 64'd0);
        check("reset.stall", 64'(stall), 64'd0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 10; v++) begin
            run_div(vecs[v].name, vecs[v].s, vecs[v].a, vecs[v].b,
                    vecs[v].hi, vecs[v].lo, vecs[v].lat, vecs[v].hold);
        end

        // Annul at the 10th BUSY cycle
        begin
            int seen;
            sgn = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
            repeat (10) tick();
            check("annul.busy_stall", 64'(stall), 64'd1);
            annul = 1'b1;
            #1;
            check("annul.stall_drop", 64'(stall), 64'd0);
            tick();
            check("annul.idle_ready", 64'(ready), 64'd0);
            check("annul.idle_stall", 64'(stall), 64'd0);
            annul = 1'b0; start = 1'b0;
            seen = 0;
            repeat (40) begin
                tick();
                if (ready || stall) seen++;
            end
            check("annul.quiet", 64'(seen), 64'd0);
            $display("annul sequence done");
            run_div("after_annul_9_3", 1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 33, 0);
        end

        // Reset mid-BUSY: sequencer must not resume and finish
        begin
            int seen;
            sgn = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
            repeat (6) tick();
            rst = 1'b1; start = 1'b0;
            tick();
            check("rst_busy.ready", 64'(ready), 64'd0);
            check("rst_busy.result", result, 64'd0);
            check("rst_busy.stall", 64'(stall), 64'd0);
            rst = 1'b0;
            seen = 0;
            repeat (40) begin
                tick();
                if (ready) seen++;
            end
            check("rst_busy.no_ready", 64'(seen), 64'd0);
            $display("reset mid-busy sequence done");
        end

        // Reset while holding a committed result
        begin
            int edges;
            sgn = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
            edges = 0;
            while (!ready && edges < 100) begin
                tick();
                edges++;
            end
            check("rst_done.ready_seen", 64'(ready), 64'd1);
            rst = 1'b1;
            tick();
            check("rst_done.ready", 64'(ready), 64'd0);
            check("rst_done.result", result, 64'd0);
            // Back in IDLE with start still high, so stall is requested again
            check("rst_done.stall", 64'(stall), 64'd1);
            rst = 1'b0; start = 1'b0;
            tick();
            $display("reset in done sequence done");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_div_ctrl.md
Name: ex_div_ctrl

Overview:
Multi-cycle divide sequencer in the EX stage, running beside the single-cycle ALU. It accepts a DIV/DIVU request from EX and runs a radix-2 restoring divide, one quotient bit per cycle. It stalls the pipeline while busy and returns {remainder, quotient} in MIPS HI/LO packing. The pipeline can annul an in-flight divide when a flush occurs.

Parameters:
DATA_W, 32, operand width; quotient and remainder are each DATA_W bits
CNT_W, $clog2(DATA_W)+1, width of the iteration counter (derived; not overridden)

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
div_start_i  input  1  divide request; must be held high until div_ready_o is seen
div_signed_i  input  1  1 = DIV (two's complement), 0 = DIVU
div_opdata1_i  input  DATA_W  dividend
div_opdata2_i  input  DATA_W  divisor
div_annul_i  input  1  flush; aborts the current operation
div_result_o  output  2*DATA_W  {remainder[2W-1:W], quotient[W-1:0]}
div_ready_o  output  1  result valid
div_stall_o  output  1  stall request to pipeline control

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, counter=0, div_result_o=0, div_ready_o=0. Reset takes priority over every other input in every state, including mid-operation.
- All outputs are registered except div_stall_o, which is combinational from state, div_start_i and div_annul_i.
- Operands are sampled only on the IDLE accept cycle. Later changes to the inputs are ignored.
- States: IDLE, DIVZERO, BUSY, DONE.
- IDLE:
  - div_start_i=1, div_annul_i=0, divisor=0 -> DIVZERO.
  - div_start_i=1, div_annul_i=0, divisor!=0 -> BUSY, counter=0.
  - Otherwise stay in IDLE.
- Signed mode, on accept:
  - Load |dividend| and |divisor| as unsigned DATA_W values. |0x8000_0000| = 0x8000_0000 unsigned.
  - Latch sign_q = sign(op1) XOR sign(op2) and sign_r = sign(op1).
- BUSY, each cycle:
  - Shift {rem, dvd} left by 1 and form trial = rem - divisor (DATA_W+1 bits).
  - If trial is non-negative: rem=trial[W-1:0] and quotient bit=1; else quotient bit=0.
  - counter increments. When counter reaches DATA_W-1 on that step -> DONE.
- DONE entry:
  - Quotient is negated if signed and sign_q=1.
  - Remainder is negated if signed and sign_r=1.
  - div_result_o is loaded and div_ready_o=1.
- DONE: result and ready hold while div_start_i=1. When div_start_i=0 -> IDLE, div_ready_o=0, div_result_o=0.
- DIVZERO: after one cycle -> DONE with quotient=all ones and remainder=raw dividend (signed and unsigned alike).
- Latency: accept at edge T, BUSY for edges T+1..T+DATA_W, div_ready_o=1 after edge T+DATA_W+1 (33 cycles at DATA_W=32). Divide-by-zero gives ready after edge T+2.
- div_stall_o = 1 when any of these holds:
  - IDLE with start=1 and annul=0;
  - state is BUSY or DIVZERO with annul=0.
  - It is 0 in DONE.
- div_annul_i=1 in BUSY or DIVZERO -> IDLE next edge; div_ready_o stays 0, div_stall_o drops the same cycle. Annul in DONE is ignored; the result is already committed.
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF gives quotient 0x8000_0000, remainder 0. No trap.
- Start asserted in BUSY or DONE with new operands has no effect.

Optional Feature:
EX_DIV_EARLY_OUT_EN
- Defined: in IDLE, if divisor!=0 and |divisor| > |dividend| (unsigned compare after abs), go straight to DONE. Quotient=0, remainder=raw dividend, ready after edge T+1.
- Undefined: every non-zero divisor takes the full DATA_W BUSY iterations.

Decomposition:
- Shared package ex_pkg holds:
  - the state enum div_state_t {IDLE, DIVZERO, BUSY, DONE};
  - localparams DIV_HI_LSB/DIV_LO_MSB for HI/LO packing;
  - the ALU opcodes for DIV/DIVU alongside the existing aluop constants.
- One sub-module, ex_div_step: combinational single-bit restoring step. Inputs rem, dvd_msb, divisor; outputs next rem and quotient bit.

Test Plan:
- Unsigned 100/7 -> result hi=0x0000_0002, lo=0x0000_000E; ready exactly 33 cycles after accept; stall high for 33 cycles.
- Signed -7/2 (0xFFFF_FFF9, 0x0000_0002) -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
- Divide-by-zero, 0x1234_5678/0 -> lo=0xFFFF_FFFF, hi=0x1234_5678, ready after 2 cycles, stall for 2 cycles.
- Signed 0x8000_0000 / 0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
- Annul at the 10th BUSY cycle:
  - next edge is IDLE, ready never rises, stall drops immediately;
  - a new 9/3 request then yields lo=3, hi=0.
- Hold start for 5 cycles after ready -> result and ready stable; deassert start -> IDLE next edge, ready=0.
- Reset asserted mid-BUSY -> the next edge clears all outputs.
